wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage and a long-latency execution unit (multi-cycle multiply/divide).
- The writeback stage is driven directly by the outputs of the MEM/WB pipeline register.
- Writeback has priority. A long-unit result that collides with it is parked in a one-entry holding buffer and drained into the next free write slot.
- Bounded starvation: after STARVE_LIMIT blocked cycles, the block stalls the pipeline for one cycle to force the drain.

Parameters:
- DATA_W, 64, register data width.
- REG_W, 5, register index width.
- ZERO_REG, 31, index of XZR; writes to it are discarded.
- STARVE_LIMIT, 4, blocked cycles with the buffer full before a forced drain (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWrite  in  1  MEM/WB write enable.
- MemtoReg  in  1  1 selects Read_data, 0 selects Alu_result.
- Read_data  in  DATA_W  MEM/WB load data.
- Alu_result  in  DATA_W  MEM/WB ALU result.
- Write_reg  in  REG_W  MEM/WB destination register.
- lu_valid  in  1  long unit presents a result.
- lu_data  in  DATA_W  long-unit result.
- lu_reg  in  REG_W  long-unit destination register.
- lu_ready  out  1  result accepted this cycle (valid & ready = transfer).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- pipe_stall  out  1  hold IF..MEM/WB this cycle; MEM/WB must re-present the same contents next cycle.
- buf_busy  out  1  holding buffer occupied, for hazard detection.
- buf_reg  out  REG_W  destination register held in the buffer (valid when buf_busy).

Behaviour:
- Definitions. pipe_wr = RegWrite & (Write_reg != ZERO_REG). pipe_data = MemtoReg ? Read_data : Alu_result.
- Write port is combinational, driven from current inputs and registered state. State, buffer and counter are registered.
- lu_ready = !buf_busy. A result to ZERO_REG is accepted and dropped: no write, no buffering.
- States: IDLE (buffer empty), HELD (buffer full), FORCE (one-cycle forced drain).
- IDLE:
  - pipe_wr: write the pipe result. A concurrent accepted lu result (non-zero reg) is captured into the buffer; count <= 0; next HELD.
  - No pipe_wr and lu_valid: write the lu result directly (bypass, zero latency); stay IDLE.
  - Otherwise: rf_we = 0.
- HELD:
  - No pipe_wr: write the buffer; buffer empties; next IDLE.
  - pipe_wr: write the pipe result; count++. When count reaches STARVE_LIMIT-1 on this cycle, next state is FORCE.
- FORCE:
  - pipe_stall = 1 and the buffer is written, regardless of RegWrite. The pipe write is not performed and is re-presented next cycle.
  - Buffer empties; next IDLE. lu_ready stays 0 this cycle because the buffer is still busy.
- pipe_stall is 1 only in FORCE and is a decode of registered state.
- Reset: state = IDLE, buffer invalid, count = 0, buf_reg = 0. Outputs: rf_we = 0, pipe_stall = 0, buf_busy = 0, lu_ready = 1. During reset all writes are suppressed and lu_valid is ignored.
- Reset asserted mid-HELD or mid-FORCE discards the buffered result, with no write.
- Counter is 4 bits and never wraps: it is cleared on every entry to HELD.
- At most one register-file write per cycle, under all input combinations.

Decomposition:
- Shared package (legv8_pkg):
  - DATA_W, REG_W, ZERO_REG constants.
  - wb_state_t enum {IDLE, HELD, FORCE}.
- One sub-module: wb_hold_buf, a one-entry valid/reg/data register with load and clear inputs. FSM, counter and write mux stay in the top level.

Test Plan:
- Reset, then RegWrite=1, Write_reg=5, MemtoReg=1, Read_data=0xAA, lu_valid=0 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA; pipe_stall=0.
- RegWrite=0; lu_valid=1, lu_reg=7, lu_data=0x1234 -> bypass write to reg 7 the same cycle; lu_ready=1; buf_busy stays 0.
- RegWrite=1, Write_reg=3, Alu_result=0x10; simultaneously lu_valid=1, lu_reg=9, lu_data=0x99; next cycle RegWrite=0 -> cycle 0 writes reg 3 and captures the lu result (buf_busy=1, buf_reg=9, lu_ready=0); cycle 1 writes reg 9 = 0x99; cycle 2 buf_busy=0.
- Buffer full (reg 9); RegWrite=1 to regs 1,2,3,4 on consecutive cycles with STARVE_LIMIT=4 -> regs 1..4 are written; the next cycle has pipe_stall=1 and writes reg 9; the reg-4 re-presentation is not written that cycle; the following cycle pipe_stall=0.
- RegWrite=1, Write_reg=31 with the buffer full -> treated as a free slot: the buffer drains this cycle and nothing is written to 31. Also: lu_valid with lu_reg=31 -> lu_ready=1, rf_we=0.
- Buffer full, reset=1 for one cycle -> next cycle buf_busy=0, lu_ready=1, rf_we=0; the buffered value is never written.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and the writeback-port arbiter state type.
package legv8_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned ZERO_REG = 31;

    // IDLE: buffer empty, HELD: buffer full, FORCE: one-cycle forced drain.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } wb_state_t;

endpackage : legv8_pkg

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a long-unit result that lost the write port.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   load                capture ld_reg/ld_data and mark the entry valid
//   clear               release the entry (load has priority; never both)
//   ld_reg, ld_data     result to capture
//   valid               entry occupied
//   buf_reg, buf_data   captured destination register and data
module wb_hold_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [REG_W-1:0]  ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [REG_W-1:0]  buf_reg,
    output logic [DATA_W-1:0] buf_data
);

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-entry selection.
    always_comb begin
        valid_d = valid_q;
        reg_d   = reg_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            reg_d   = ld_reg;
            data_d  = ld_data;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage; reset discards any held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign buf_reg  = reg_q;
    assign buf_data = data_q;

endmodule : wb_hold_buf

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM/WB writeback stage
// (priority) and a long-latency execution unit. A colliding long-unit result
// is parked in a one-entry buffer; after STARVE_LIMIT blocked cycles the
// pipeline is stalled for one cycle to force the drain.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   RegWrite, MemtoReg,
//   Read_data, Alu_result,
//   Write_reg                    MEM/WB register outputs
//   lu_valid, lu_data, lu_reg    long-unit result offer
//   lu_ready                     long-unit result accepted this cycle
//   rf_we, rf_waddr, rf_wdata    register-file write port (combinational)
//   pipe_stall                   hold IF..MEM/WB this cycle
//   buf_busy, buf_reg            holding-buffer status for hazard detection
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = legv8_pkg::DATA_W,
    parameter int unsigned REG_W        = legv8_pkg::REG_W,
    parameter int unsigned ZERO_REG     = legv8_pkg::ZERO_REG,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] Read_data,
    input  logic [DATA_W-1:0] Alu_result,
    input  logic [REG_W-1:0]  Write_reg,
    input  logic              lu_valid,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [REG_W-1:0]  lu_reg,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic              buf_busy,
    output logic [REG_W-1:0]  buf_reg
);

    import legv8_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    wb_state_t         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pipe_wr;
    logic [DATA_W-1:0] pipe_data;
    logic              lu_live;
    logic              buf_load;
    logic              buf_clear;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;

    wb_hold_buf #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_hold_buf (
        .clock    (clock),
        .reset    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .ld_reg   (lu_reg),
        .ld_data  (lu_data),
        .valid    (buf_valid),
        .buf_reg  (buf_reg),
        .buf_data (buf_data)
    );

    // Writes to XZR are never real writes, so they leave the port free.
    assign pipe_wr   = RegWrite && (Write_reg != ZERO_IDX);
    assign pipe_data = MemtoReg ? Read_data : Alu_result;
    assign lu_live   = lu_valid && (lu_reg != ZERO_IDX);

    assign buf_busy   = buf_valid;
    assign lu_ready   = !buf_valid;
    assign pipe_stall = (state_q == FORCE);

    // Next state, counter, buffer control and write-port mux.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (pipe_wr) begin
                    rf_we    = 1'b1;
                    rf_waddr = Write_reg;
                    rf_wdata = pipe_data;
                    if (lu_live) begin
                        buf_load = 1'b1;
                        count_d  = '0;
                        state_d  = HELD;
                    end
                end else if (lu_live) begin
                    rf_we    = 1'b1;
                    rf_waddr = lu_reg;
                    rf_wdata = lu_data;
                end
            end
            HELD: begin
                if (pipe_wr) begin
                    rf_we    = 1'b1;
                    rf_waddr = Write_reg;
                    rf_wdata = pipe_data;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) begin
                        state_d = FORCE;
                    end
                end else begin
                    rf_we     = 1'b1;
                    rf_waddr  = buf_reg;
                    rf_wdata  = buf_data;
                    buf_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            FORCE: begin
                // Pipe is stalled; its write is re-presented next cycle.
                rf_we     = 1'b1;
                rf_waddr  = buf_reg;
                rf_wdata  = buf_data;
                buf_clear = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No writes and no captures while reset is asserted.
        if (reset) begin
            rf_we     = 1'b0;
            rf_waddr  = '0;
            rf_wdata  = '0;
            buf_load  = 1'b0;
            buf_clear = 1'b0;
        end
    end

    // State and starvation counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a per-cycle expectation queue.
module tb_wb_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic        MemtoReg;
    logic [63:0] Read_data;
    logic [63:0] Alu_result;
    logic [4:0]  Write_reg;
    logic        lu_valid;
    logic [63:0] lu_data;
    logic [4:0]  lu_reg;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        pipe_stall;
    logic        buf_busy;
    logic [4:0]  buf_reg;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        stall;
        logic        busy;
        logic        ready;
        logic [4:0]  breg;
    } exp_t;

    exp_t sb[$];

    wb_port_arbiter #(
        .DATA_W       (64),
        .REG_W        (5),
        .ZERO_REG     (31),
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .Read_data  (Read_data),
        .Alu_result (Alu_result),
        .Write_reg  (Write_reg),
        .lu_valid   (lu_valid),
        .lu_data    (lu_data),
        .lu_reg     (lu_reg),
        .lu_ready   (lu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pipe_stall (pipe_stall),
        .buf_busy   (buf_busy),
        .buf_reg    (buf_reg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic rw, input logic mtr, input logic [63:0] rd,
                          input logic [63:0] alu, input logic [4:0] wr,
                          input logic luv, input logic [63:0] lud, input logic [4:0] lur);
        RegWrite   = rw;
        MemtoReg   = mtr;
        Read_data  = rd;
        Alu_result = alu;
        Write_reg  = wr;
        lu_valid   = luv;
        lu_data    = lud;
        lu_reg     = lur;
    endtask

    task automatic push(input string tag, input logic we, input logic [4:0] a,
                        input logic [63:0] d, input logic st, input logic bb,
                        input logic rdy, input logic [4:0] br);
        exp_t e;
        e.tag = tag; e.we = we; e.addr = a; e.data = d;
        e.stall = st; e.busy = bb; e.ready = rdy; e.breg = br;
        sb.push_back(e);
    endtask

    // Compare the settled outputs mid-cycle, then advance past the next edge.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_we"}, 64'(rf_we), 64'(e.we));
            if (e.we) begin
                chk({e.tag, "_waddr"}, 64'(rf_waddr), 64'(e.addr));
                chk({e.tag, "_wdata"}, rf_wdata, e.data);
            end
            chk({e.tag, "_stall"}, 64'(pipe_stall), 64'(e.stall));
            chk({e.tag, "_busy"}, 64'(buf_busy), 64'(e.busy));
            chk({e.tag, "_ready"}, 64'(lu_ready), 64'(e.ready));
            if (e.busy) chk({e.tag, "_breg"}, 64'(buf_reg), 64'(e.breg));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        @(posedge clock);
        #1;
        // Write request during reset is suppressed.
        set_in(1'b1, 1'b0, '0, 64'h77, 5'd2, 1'b1, 64'h5, 5'd6);
        push("in_reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);            cycle();
        reset = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        push("after_reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);         cycle();

        // Plain pipe write, load data selected.
        set_in(1'b1, 1'b1, 64'hAA, 64'h55, 5'd5, 1'b0, '0, '0);
        push("pipe_load", 1'b1, 5'd5, 64'hAA, 1'b0, 1'b0, 1'b1, 0);   cycle();
        // Long-unit bypass.
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b1, 64'h1234, 5'd7);
        push("lu_bypass", 1'b1, 5'd7, 64'h1234, 1'b0, 1'b0, 1'b1, 0); cycle();
        // Collision: pipe wins, lu captured, drained next cycle.
        set_in(1'b1, 1'b0, 64'hEE, 64'h10, 5'd3, 1'b1, 64'h99, 5'd9);
        push("collide", 1'b1, 5'd3, 64'h10, 1'b0, 1'b0, 1'b1, 0);     cycle();
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        push("drain", 1'b1, 5'd9, 64'h99, 1'b0, 1'b1, 1'b0, 5'd9);    cycle();
        push("drained", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);             cycle();

        // Starvation: fill, then four blocked pipe writes, then forced drain.
        set_in(1'b1, 1'b0, '0, 64'h80, 5'd8, 1'b1, 64'h999, 5'd9);
        push("fill1", 1'b1, 5'd8, 64'h80, 1'b0, 1'b0, 1'b1, 0);       cycle();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 1'b0, '0, 64'(i), 5'(i), 1'b1, 64'hBAD, 5'd12);
            push($sformatf("starve%0d", i), 1'b1, 5'(i), 64'(i), 1'b0, 1'b1, 1'b0, 5'd9);
            cycle();
        end
        set_in(1'b1, 1'b0, '0, 64'h4, 5'd4, 1'b0, '0, '0);
        push("force", 1'b1, 5'd9, 64'h999, 1'b1, 1'b1, 1'b0, 5'd9);   cycle();
        push("represent", 1'b1, 5'd4, 64'h4, 1'b0, 1'b0, 1'b1, 0);    cycle();
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        push("quiet1", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);              cycle();

        // Pipe write to XZR is a free slot for the buffer.
        set_in(1'b1, 1'b0, '0, 64'hA0, 5'd10, 1'b1, 64'hBB, 5'd11);
        push("fill2", 1'b1, 5'd10, 64'hA0, 1'b0, 1'b0, 1'b1, 0);      cycle();
        set_in(1'b1, 1'b0, '0, 64'hFF, 5'd31, 1'b0, '0, '0);
        push("xzr_drain", 1'b1, 5'd11, 64'hBB, 1'b0, 1'b1, 1'b0, 5'd11); cycle();
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        push("quiet2", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);              cycle();
        // Long-unit result to XZR is accepted and dropped.
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b1, 64'hDEAD, 5'd31);
        push("lu_xzr", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);              cycle();
        set_in(1'b1, 1'b0, '0, 64'h66, 5'd6, 1'b1, 64'hDEAD, 5'd31);
        push("pipe_lu_xzr", 1'b1, 5'd6, 64'h66, 1'b0, 1'b0, 1'b1, 0); cycle();
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        push("no_capture", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);          cycle();

        // Reset while HELD discards the buffered result.
        set_in(1'b1, 1'b0, '0, 64'hD, 5'd13, 1'b1, 64'hEE, 5'd14);
        push("fill3", 1'b1, 5'd13, 64'hD, 1'b0, 1'b0, 1'b1, 0);       cycle();
        reset = 1'b1;
        set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        push("reset_held", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 5'd14);      cycle();
        reset = 1'b0;
        push("post_reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);          cycle();
        push("post_reset2", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 0);         cycle();

        chk("scoreboard_leftover", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_wb_port_arbiter
